// File: rtl/priority_encoder_pipe.sv
// priority_encoder_pipe: two-stage pipelined two-sided priority encoder.
// Stage 1 reduces each SEG_WIDTH-bit segment to an any-bit flag plus local
// highest/lowest indices; stage 2 picks the outermost non-empty segments,
// forms the global indices and decodes the one-hot masks. Valid/ready on
// both sides, with full throughput and backpressure absorption of two words.
module priority_encoder_pipe #(
  parameter  int WIDTH     = 16,
  parameter  int SEG_WIDTH = 4,
  localparam int IDX_W     = $clog2(WIDTH),
  localparam int NSEG      = WIDTH / SEG_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  output logic             data_rdy_o,
  output logic [WIDTH-1:0] data_left_o,
  output logic [WIDTH-1:0] data_right_o,
  output logic [IDX_W-1:0] left_idx_o,
  output logic [IDX_W-1:0] right_idx_o,
  output logic             zero_o,
  output logic             data_val_o,
  input  logic             data_rdy_i
);

  // Local index storage is kept at least one bit wide; with one-bit segments
  // the local index is always zero.
  localparam int LW = (SEG_WIDTH > 1) ? $clog2(SEG_WIDTH) : 1;

  generate
    if (WIDTH < 2 || SEG_WIDTH < 1 || SEG_WIDTH > WIDTH || (WIDTH % SEG_WIDTH) != 0) begin : g_bad_param
      $error("priority_encoder_pipe: illegal WIDTH/SEG_WIDTH combination");
    end
  endgenerate

  logic s1_adv;
  logic s2_adv;
  logic s1_val;
  logic s2_val;

  logic [NSEG-1:0] seg_any;
  logic [LW-1:0]   seg_hi [NSEG];
  logic [LW-1:0]   seg_lo [NSEG];

  logic [NSEG-1:0] s1_any;
  logic [LW-1:0]   s1_hi [NSEG];
  logic [LW-1:0]   s1_lo [NSEG];

  logic [IDX_W-1:0] nxt_left_idx;
  logic [IDX_W-1:0] nxt_right_idx;
  logic [WIDTH-1:0] nxt_left;
  logic [WIDTH-1:0] nxt_right;
  logic             nxt_zero;

  // A stage may move when the stage after it can take its contents.
  assign s2_adv     = ~s2_val | data_rdy_i;
  assign s1_adv     = ~s1_val | s2_adv;
  assign data_rdy_o = rst_n_i & s1_adv;
  assign data_val_o = s2_val;

  // Per-segment reduction: any-bit flag, local highest and lowest set bit.
  always_comb begin
    for (int s = 0; s < NSEG; s++) begin
      seg_any[s] = 1'b0;
      seg_hi[s]  = '0;
      seg_lo[s]  = '0;
      for (int b = 0; b < SEG_WIDTH; b++) begin
        if (data_i[s*SEG_WIDTH + b]) begin
          seg_any[s] = 1'b1;
          seg_hi[s]  = LW'(b);
        end
      end
      for (int b = SEG_WIDTH - 1; b >= 0; b--) begin
        if (data_i[s*SEG_WIDTH + b]) begin
          seg_lo[s] = LW'(b);
        end
      end
    end
  end

  // Stage 1 register: loads on advance, clears valid on an upstream bubble.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_val <= 1'b0;
      s1_any <= '0;
      for (int s = 0; s < NSEG; s++) begin
        s1_hi[s] <= '0;
        s1_lo[s] <= '0;
      end
    end else if (s1_adv) begin
      s1_val <= data_val_i;
      if (data_val_i) begin
        s1_any <= seg_any;
        for (int s = 0; s < NSEG; s++) begin
          s1_hi[s] <= seg_hi[s];
          s1_lo[s] <= seg_lo[s];
        end
      end
    end
  end

  // Segment selection: the last hit of the upward scan is the highest
  // non-empty segment, the last hit of the downward scan the lowest.
  always_comb begin
    nxt_left_idx  = '0;
    nxt_right_idx = '0;
    for (int s = 0; s < NSEG; s++) begin
      if (s1_any[s]) begin
        nxt_left_idx = IDX_W'(s*SEG_WIDTH + int'(s1_hi[s]));
      end
    end
    for (int s = NSEG - 1; s >= 0; s--) begin
      if (s1_any[s]) begin
        nxt_right_idx = IDX_W'(s*SEG_WIDTH + int'(s1_lo[s]));
      end
    end
    nxt_zero  = ~|s1_any;
    nxt_left  = nxt_zero ? '0 : (WIDTH'(1) << nxt_left_idx);
    nxt_right = nxt_zero ? '0 : (WIDTH'(1) << nxt_right_idx);
  end

  // Stage 2 / output register: holds everything while the consumer stalls.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_val       <= 1'b0;
      data_left_o  <= '0;
      data_right_o <= '0;
      left_idx_o   <= '0;
      right_idx_o  <= '0;
      zero_o       <= 1'b0;
    end else if (s2_adv) begin
      s2_val <= s1_val;
      if (s1_val) begin
        data_left_o  <= nxt_left;
        data_right_o <= nxt_right;
        left_idx_o   <= nxt_left_idx;
        right_idx_o  <= nxt_right_idx;
        zero_o       <= nxt_zero;
      end
    end
  end

endmodule

// File: tb/tb_priority_encoder_pipe.sv
// Testbench for priority_encoder_pipe: directed scenarios on a 16/4 instance,
// plus random streams on 8/8 and 32/1 instances against a bit-scan model.
module tb_priority_encoder_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // 16/4 instance
  logic [15:0] a_data = '0;
  logic        a_val_i = 1'b0;
  logic        a_rdy_o;
  logic [15:0] a_left, a_right;
  logic [3:0]  a_lidx, a_ridx;
  logic        a_zero, a_val_o;
  logic        a_rdy_i = 1'b0;

  // 8/8 instance
  logic [7:0]  b_data = '0;
  logic        b_val_i = 1'b0;
  logic        b_rdy_o;
  logic [7:0]  b_left, b_right;
  logic [2:0]  b_lidx, b_ridx;
  logic        b_zero, b_val_o;
  logic        b_rdy_i = 1'b0;

  // 32/1 instance
  logic [31:0] c_data = '0;
  logic        c_val_i = 1'b0;
  logic        c_rdy_o;
  logic [31:0] c_left, c_right;
  logic [4:0]  c_lidx, c_ridx;
  logic        c_zero, c_val_o;
  logic        c_rdy_i = 1'b0;

  priority_encoder_pipe #(.WIDTH(16), .SEG_WIDTH(4)) u_a (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(a_data), .data_val_i(a_val_i), .data_rdy_o(a_rdy_o),
    .data_left_o(a_left), .data_right_o(a_right), .left_idx_o(a_lidx), .right_idx_o(a_ridx),
    .zero_o(a_zero), .data_val_o(a_val_o), .data_rdy_i(a_rdy_i));

  priority_encoder_pipe #(.WIDTH(8), .SEG_WIDTH(8)) u_b (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(b_data), .data_val_i(b_val_i), .data_rdy_o(b_rdy_o),
    .data_left_o(b_left), .data_right_o(b_right), .left_idx_o(b_lidx), .right_idx_o(b_ridx),
    .zero_o(b_zero), .data_val_o(b_val_o), .data_rdy_i(b_rdy_i));

  priority_encoder_pipe #(.WIDTH(32), .SEG_WIDTH(1)) u_c (
    .clk_i(clk), .rst_n_i(rst_n), .data_i(c_data), .data_val_i(c_val_i), .data_rdy_o(c_rdy_o),
    .data_left_o(c_left), .data_right_o(c_right), .left_idx_o(c_lidx), .right_idx_o(c_ridx),
    .zero_o(c_zero), .data_val_o(c_val_o), .data_rdy_i(c_rdy_i));

  // Reference: plain bit scan over the low w bits of d.
  function automatic void model(input logic [31:0] d, input int w,
                                output logic [31:0] l, output logic [31:0] r,
                                output int li, output int ri, output logic z);
    li = 0; ri = 0; z = 1'b1;
    for (int i = 0; i < w; i++) if (d[i]) begin li = i; z = 1'b0; end
    for (int i = w - 1; i >= 0; i--) if (d[i]) ri = i;
    l = z ? 32'h0 : (32'h1 << li);
    r = z ? 32'h0 : (32'h1 << ri);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_cmp++; if (a_val_o !== 1'b0) begin n_err++; $display("FAIL reset_val_o: got %b want 0", a_val_o); end
    n_cmp++; if (a_rdy_o !== 1'b0) begin n_err++; $display("FAIL reset_rdy_o: got %b want 0", a_rdy_o); end
    n_cmp++; if (a_left !== 16'h0 || a_right !== 16'h0) begin n_err++; $display("FAIL reset_masks: got %h/%h want 0/0", a_left, a_right); end
    n_cmp++; if (a_lidx !== 4'd0 || a_ridx !== 4'd0) begin n_err++; $display("FAIL reset_idx: got %0d/%0d want 0/0", a_lidx, a_ridx); end
    n_cmp++; if (a_zero !== 1'b0) begin n_err++; $display("FAIL reset_zero: got %b want 0", a_zero); end
    n_cmp++; if (b_rdy_o !== 1'b0 || c_rdy_o !== 1'b0) begin n_err++; $display("FAIL reset_rdy_bc: got %b/%b want 0/0", b_rdy_o, c_rdy_o); end
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    n_cmp++; if (a_rdy_o !== 1'b1) begin n_err++; $display("FAIL release_rdy_o: got %b want 1", a_rdy_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    a_rdy_i = 1'b1;
    a_data = 16'h0810; a_val_i = 1'b1;
    @(posedge clk); #1;
    a_val_i = 1'b0; a_data = 16'h0;
    n_cmp++; if (a_val_o !== 1'b0) begin n_err++; $display("FAIL basic_latency: val_o got %b want 0 after one edge", a_val_o); end
    @(posedge clk); #1;
    n_cmp++; if (a_val_o !== 1'b1) begin n_err++; $display("FAIL basic_val: got %b want 1", a_val_o); end
    n_cmp++; if (a_left !== 16'h0800 || a_lidx !== 4'd11) begin n_err++; $display("FAIL basic_left: got %h/%0d want 0800/11", a_left, a_lidx); end
    n_cmp++; if (a_right !== 16'h0010 || a_ridx !== 4'd4) begin n_err++; $display("FAIL basic_right: got %h/%0d want 0010/4", a_right, a_ridx); end
    n_cmp++; if (a_zero !== 1'b0) begin n_err++; $display("FAIL basic_zero: got %b want 0", a_zero); end
    @(posedge clk); #1;
    n_cmp++; if (a_val_o !== 1'b0) begin n_err++; $display("FAIL basic_drain: val_o got %b want 0", a_val_o); end
  endtask

  task automatic test_back_to_back();
    a_rdy_i = 1'b1;
    a_data = 16'h8001; a_val_i = 1'b1;
    @(posedge clk); #1;
    a_data = 16'h0000;
    n_cmp++; if (a_rdy_o !== 1'b1) begin n_err++; $display("FAIL b2b_rdy: got %b want 1", a_rdy_o); end
    @(posedge clk); #1;
    a_val_i = 1'b0;
    n_cmp++; if (a_val_o !== 1'b1 || a_left !== 16'h8000 || a_lidx !== 4'd15 || a_right !== 16'h0001 || a_ridx !== 4'd0 || a_zero !== 1'b0) begin
      n_err++; $display("FAIL b2b_first: got val=%b %h/%0d %h/%0d z=%b want 1 8000/15 0001/0 z=0", a_val_o, a_left, a_lidx, a_right, a_ridx, a_zero);
    end
    @(posedge clk); #1;
    n_cmp++; if (a_val_o !== 1'b1 || a_left !== 16'h0 || a_lidx !== 4'd0 || a_right !== 16'h0 || a_ridx !== 4'd0 || a_zero !== 1'b1) begin
      n_err++; $display("FAIL b2b_zero: got val=%b %h/%0d %h/%0d z=%b want 1 0000/0 0000/0 z=1", a_val_o, a_left, a_lidx, a_right, a_ridx, a_zero);
    end
    @(posedge clk); #1;
    n_cmp++; if (a_val_o !== 1'b0) begin n_err++; $display("FAIL b2b_drain: val_o got %b want 0", a_val_o); end
  endtask

  task automatic test_stall();
    logic [15:0] w [4];
    int ptr, accepts;
    int lq[$];
    int rq[$];
    w[0] = 16'h0001; w[1] = 16'h0002; w[2] = 16'h0004; w[3] = 16'h0008;
    ptr = 0; accepts = 0;
    a_rdy_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_val_i = 1'b1; a_data = w[ptr];
      #1;
      if (i >= 2) begin
        n_cmp++; if (a_val_o !== 1'b1 || a_left !== 16'h0001 || a_lidx !== 4'd0 || a_right !== 16'h0001 || a_zero !== 1'b0) begin
          n_err++; $display("FAIL stall_hold: cycle %0d got val=%b left=%h idx=%0d right=%h z=%b want 1 0001 0 0001 0", i, a_val_o, a_left, a_lidx, a_right, a_zero);
        end
      end
      if (a_val_i && a_rdy_o) begin ptr++; accepts++; end
      @(posedge clk); #1;
    end
    a_val_i = 1'b1; a_data = w[ptr];
    #1;
    n_cmp++; if (accepts !== 2) begin n_err++; $display("FAIL stall_accepts: got %0d want 2", accepts); end
    n_cmp++; if (a_rdy_o !== 1'b0) begin n_err++; $display("FAIL stall_rdy_low: got %b want 0", a_rdy_o); end
    a_rdy_i = 1'b1;
    #1;
    n_cmp++; if (a_rdy_o !== 1'b1) begin n_err++; $display("FAIL stall_rdy_rise: got %b want 1", a_rdy_o); end
    for (int i = 0; i < 10; i++) begin
      a_val_i = (ptr < 4);
      a_data = (ptr < 4) ? w[ptr] : 16'h0;
      #1;
      if (a_val_o && a_rdy_i) begin lq.push_back(int'(a_lidx)); rq.push_back(int'(a_ridx)); end
      if (a_val_i && a_rdy_o) ptr++;
      @(posedge clk); #1;
    end
    a_val_i = 1'b0;
    n_cmp++; if (lq.size() !== 4) begin n_err++; $display("FAIL stall_count: got %0d results want 4", lq.size()); end
    for (int k = 0; k < lq.size() && k < 4; k++) begin
      n_cmp++; if (lq[k] !== k || rq[k] !== k) begin n_err++; $display("FAIL stall_order: result %0d got idx %0d/%0d want %0d/%0d", k, lq[k], rq[k], k, k); end
    end
  endtask

  task automatic test_reset_midstream();
    int seen;
    a_rdy_i = 1'b0;
    a_data = 16'h00F0; a_val_i = 1'b1;
    @(posedge clk); #1;
    a_data = 16'h0F00;
    @(posedge clk); #1;
    a_val_i = 1'b0;
    n_cmp++; if (a_val_o !== 1'b1) begin n_err++; $display("FAIL mid_precond: val_o got %b want 1", a_val_o); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (a_val_o !== 1'b0 || a_rdy_o !== 1'b0) begin n_err++; $display("FAIL mid_async: val_o/rdy_o got %b/%b want 0/0", a_val_o, a_rdy_o); end
    n_cmp++; if (a_left !== 16'h0 || a_lidx !== 4'd0 || a_right !== 16'h0 || a_zero !== 1'b0) begin
      n_err++; $display("FAIL mid_outs_clear: got %h/%0d %h z=%b want 0/0 0 z=0", a_left, a_lidx, a_right, a_zero);
    end
    #2;
    rst_n = 1'b1;
    a_rdy_i = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (a_val_o) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL mid_no_ghost: got %0d stale results want 0", seen); end
    a_data = 16'h0100; a_val_i = 1'b1;
    @(posedge clk); #1;
    a_val_i = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (a_val_o !== 1'b1 || a_left !== 16'h0100 || a_right !== 16'h0100 || a_lidx !== 4'd8 || a_ridx !== 4'd8 || a_zero !== 1'b0) begin
      n_err++; $display("FAIL mid_after: got val=%b %h/%0d %h/%0d z=%b want 1 0100/8 0100/8 z=0", a_val_o, a_left, a_lidx, a_right, a_ridx, a_zero);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    localparam int N = 10000;
    fork
      begin : rand8
        logic [7:0] q[$];
        logic [7:0] d;
        logic [31:0] el, er;
        int eli, eri, sent, rcv;
        logic ez;
        sent = 0; rcv = 0;
        for (int cyc = 0; cyc < 40000 && rcv < N; cyc++) begin
          b_rdy_i = ($urandom_range(0, 3) != 0);
          if (sent < N && $urandom_range(0, 4) != 0) begin
            case ($urandom_range(0, 9))
              0: b_data = 8'h00;
              1: b_data = 8'hFF;
              2: b_data = 8'h01 << $urandom_range(0, 7);
              default: b_data = 8'($urandom);
            endcase
            b_val_i = 1'b1;
          end else b_val_i = 1'b0;
          #1;
          if (b_val_o && b_rdy_i) begin
            n_cmp++;
            if (q.size() == 0) begin n_err++; $display("FAIL rand8_extra: result with no word outstanding"); end
            else begin
              d = q.pop_front();
              model({24'h0, d}, 8, el, er, eli, eri, ez);
              if ({24'h0, b_left} !== el || {24'h0, b_right} !== er || int'(b_lidx) !== eli || int'(b_ridx) !== eri || b_zero !== ez) begin
                n_err++; $display("FAIL rand8: data=%h got %h/%0d %h/%0d z=%b want %h/%0d %h/%0d z=%b", d, b_left, b_lidx, b_right, b_ridx, b_zero, el[7:0], eli, er[7:0], eri, ez);
              end
            end
            rcv++;
          end
          if (b_val_i && b_rdy_o) begin q.push_back(b_data); sent++; end
          @(posedge clk); #1;
        end
        b_val_i = 1'b0;
        n_cmp++; if (rcv !== N || q.size() !== 0) begin n_err++; $display("FAIL rand8_count: got %0d results, %0d pending want %0d, 0", rcv, q.size(), N); end
      end
      begin : rand32
        logic [31:0] q[$];
        logic [31:0] d;
        logic [31:0] el, er;
        int eli, eri, sent, rcv;
        logic ez;
        sent = 0; rcv = 0;
        for (int cyc = 0; cyc < 40000 && rcv < N; cyc++) begin
          c_rdy_i = ($urandom_range(0, 3) != 0);
          if (sent < N && $urandom_range(0, 4) != 0) begin
            case ($urandom_range(0, 9))
              0: c_data = 32'h0;
              1: c_data = 32'hFFFF_FFFF;
              2: c_data = 32'h1 << $urandom_range(0, 31);
              default: c_data = $urandom;
            endcase
            c_val_i = 1'b1;
          end else c_val_i = 1'b0;
          #1;
          if (c_val_o && c_rdy_i) begin
            n_cmp++;
            if (q.size() == 0) begin n_err++; $display("FAIL rand32_extra: result with no word outstanding"); end
            else begin
              d = q.pop_front();
              model(d, 32, el, er, eli, eri, ez);
              if (c_left !== el || c_right !== er || int'(c_lidx) !== eli || int'(c_ridx) !== eri || c_zero !== ez) begin
                n_err++; $display("FAIL rand32: data=%h got %h/%0d %h/%0d z=%b want %h/%0d %h/%0d z=%b", d, c_left, c_lidx, c_right, c_ridx, c_zero, el, eli, er, eri, ez);
              end
            end
            rcv++;
          end
          if (c_val_i && c_rdy_o) begin q.push_back(c_data); sent++; end
          @(posedge clk); #1;
        end
        c_val_i = 1'b0;
        n_cmp++; if (rcv !== N || q.size() !== 0) begin n_err++; $display("FAIL rand32_count: got %0d results, %0d pending want %0d, 0", rcv, q.size(), N); end
      end
    join
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_stall();
    test_reset_midstream();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
